digit_scan_blinker: RTL and testbench



---
 rtl/display_pkg.sv | 27 ++
 rtl/blink_timer.sv | 30 +++
 rtl/digit_scan_blinker.sv | 93 +++++++++
 tb/tb_digit_scan_blinker.sv | 138 +++++++++++++
 4 files changed

// File: rtl/display_pkg.sv
// Shared 7-segment display helpers: segment constants and the BCD decode table.
// Segment vectors are {a,b,c,d,e,f,g}, active-high.
package display_pkg;

    localparam logic [6:0] SEG_BLANK = 7'b0000000;
    localparam logic [6:0] SEG_DASH  = 7'b0000001;

    // Codes above 9 show a dash, which the alarm display uses for unset digits.
    function automatic logic [6:0] seg_decode(input logic [3:0] code);
        logic [6:0] pat;
        case (code)
            4'd0:    pat = 7'b1111110;
            4'd1:    pat = 7'b0110000;
            4'd2:    pat = 7'b1101101;
            4'd3:    pat = 7'b1111001;
            4'd4:    pat = 7'b0110011;
            4'd5:    pat = 7'b1011011;
            4'd6:    pat = 7'b1011111;
            4'd7:    pat = 7'b1110000;
            4'd8:    pat = 7'b1111111;
            4'd9:    pat = 7'b1111011;
            default: pat = SEG_DASH;
        endcase
        return pat;
    endfunction

endpackage

// File: rtl/blink_timer.sv
// Blink phase generator: blink_on toggles every BLINK_HALF cycles of msecclk.
// blink_sync restarts the visible half immediately.
module blink_timer #(
    parameter int BLINK_HALF = 256
) (
    input  logic msecclk,
    input  logic rst,
    input  logic blink_sync,
    output logic blink_on
);

    localparam int CNT_W = $clog2(BLINK_HALF);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_HALF - 1);

    logic [CNT_W-1:0] blink_cnt;

    // A sync pulse wins over a terminal-count toggle in the same cycle.
    always_ff @(posedge msecclk) begin
        if (rst || blink_sync) begin
            blink_cnt <= '0;
            blink_on  <= 1'b1;
        end else if (blink_cnt == CNT_LAST) begin
            blink_cnt <= '0;
            blink_on  <= ~blink_on;
        end else begin
            blink_cnt <= blink_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/digit_scan_blinker.sv
// Multiplexed 7-segment scanner with per-digit blink and blank masks.
// Pins are registered from the pre-edge digit index, so an and seg switch together.
module digit_scan_blinker
    import display_pkg::*;
#(
    parameter int DIGITS     = 8,
    parameter int SCAN_DIV   = 2,
    parameter int BLINK_HALF = 256,
    parameter int ACTIVE_LOW = 1
) (
    input  logic                  msecclk,
    input  logic                  rst,
    input  logic [4*DIGITS-1:0]   digit_code,
    input  logic [DIGITS-1:0]     dp_mask,
    input  logic [DIGITS-1:0]     blink_mask,
    input  logic [DIGITS-1:0]     blank_mask,
    input  logic                  blink_sync,
    output logic [DIGITS-1:0]     an,
    output logic [7:0]            seg,
    output logic                  blink_on
);

    localparam int IDX_W  = $clog2(DIGITS);
    localparam int SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(DIGITS - 1);
    localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);
    localparam logic              POL       = (ACTIVE_LOW != 0);

    logic [SCAN_W-1:0] scan_cnt;
    logic [IDX_W-1:0]  idx;

    logic [3:0]        cur_code;
    logic              cur_dp;
    logic              cur_blink;
    logic              cur_blank;
    logic [DIGITS-1:0] onehot;
    logic              vis;
    logic [DIGITS-1:0] an_nxt;
    logic [7:0]        seg_nxt;

    blink_timer #(
        .BLINK_HALF (BLINK_HALF)
    ) u_blink (
        .msecclk    (msecclk),
        .rst        (rst),
        .blink_sync (blink_sync),
        .blink_on   (blink_on)
    );

    always_ff @(posedge msecclk) begin
        if (rst) begin
            scan_cnt <= '0;
            idx      <= '0;
        end else if (scan_cnt == SCAN_LAST) begin
            scan_cnt <= '0;
            idx      <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
        end else begin
            scan_cnt <= scan_cnt + 1'b1;
        end
    end

    // Mux-by-compare keeps non-power-of-two DIGITS from selecting past the top digit.
    always_comb begin
        cur_code  = '0;
        cur_dp    = 1'b0;
        cur_blink = 1'b0;
        cur_blank = 1'b0;
        onehot    = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (idx == IDX_W'(i)) begin
                cur_code  = digit_code[4*i +: 4];
                cur_dp    = dp_mask[i];
                cur_blink = blink_mask[i];
                cur_blank = blank_mask[i];
                onehot[i] = 1'b1;
            end
        end
        vis     = !cur_blank && (!cur_blink || blink_on);
        an_nxt  = vis ? onehot : '0;
        seg_nxt = vis ? {seg_decode(cur_code), cur_dp} : {SEG_BLANK, 1'b0};
    end

    always_ff @(posedge msecclk) begin
        if (rst) begin
            an  <= {DIGITS{POL}};
            seg <= {8{POL}};
        end else begin
            an  <= an_nxt ^ {DIGITS{POL}};
            seg <= seg_nxt ^ {8{POL}};
        end
    end

endmodule

// File: tb/tb_digit_scan_blinker.sv
// Randomized bench: two scanner configurations against a cycle-count reference model.
module tb_digit_scan_blinker;

    logic        msecclk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] digit_code = 32'h1234_5678;
    logic [7:0]  dp_mask = '0;
    logic [7:0]  blink_mask = '0;
    logic [7:0]  blank_mask = '0;
    logic        blink_sync = 1'b0;

    logic [7:0]  an_a;
    logic [7:0]  seg_a;
    logic        on_a;
    logic [3:0]  an_b;
    logic [7:0]  seg_b;
    logic        on_b;

    int n_cmp = 0;
    int n_bad = 0;

    // Model state: edges since reset (scan position) and since reset/sync (blink phase).
    int scan_t = 0;
    int since  = 0;

    localparam int HALF_A = 256;
    localparam int HALF_B = 4;

    digit_scan_blinker #(
        .DIGITS(8), .SCAN_DIV(2), .BLINK_HALF(HALF_A), .ACTIVE_LOW(1)
    ) dut_a (
        .msecclk(msecclk), .rst(rst), .digit_code(digit_code), .dp_mask(dp_mask),
        .blink_mask(blink_mask), .blank_mask(blank_mask), .blink_sync(blink_sync),
        .an(an_a), .seg(seg_a), .blink_on(on_a)
    );

    digit_scan_blinker #(
        .DIGITS(4), .SCAN_DIV(1), .BLINK_HALF(HALF_B), .ACTIVE_LOW(0)
    ) dut_b (
        .msecclk(msecclk), .rst(rst), .digit_code(digit_code[15:0]), .dp_mask(dp_mask[3:0]),
        .blink_mask(blink_mask[3:0]), .blank_mask(blank_mask[3:0]), .blink_sync(blink_sync),
        .an(an_b), .seg(seg_b), .blink_on(on_b)
    );

    always #5 msecclk = ~msecclk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s at t=%0t: got %0h, expected %0h", tag, $time, got, exp);
        end
    endtask

    function automatic logic [6:0] ref_seg(input logic [3:0] c);
        logic [6:0] t [10];
        t = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70, 7'h7F, 7'h7B};
        if (c > 4'd9) return 7'h01;
        return t[c];
    endfunction

    // Expected {an, seg} for a scanner of the given shape, from elapsed-cycle counts.
    function automatic logic [15:0] model_pins(input int digits, input int scan_div, input int half,
                                               input bit al, input int st, input int sn,
                                               input logic [31:0] code, input logic [7:0] dp,
                                               input logic [7:0] blk, input logic [7:0] bln);
        int idx;
        bit on;
        bit vis;
        logic [7:0] a;
        logic [7:0] s;
        idx = (st / scan_div) % digits;
        on  = ((sn / half) % 2) == 0;
        vis = !bln[idx] && (!blk[idx] || on);
        a = '0;
        s = '0;
        if (vis) begin
            a[idx] = 1'b1;
            s = {ref_seg(code[4*idx +: 4]), dp[idx]};
        end
        if (al) begin
            a = a ^ 8'((1 << digits) - 1);
            s = ~s;
        end
        return {a, s};
    endfunction

    initial begin
        logic [15:0] exp_a;
        logic [15:0] exp_b;
        bit          eon_a;
        bit          eon_b;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge msecclk);
            rst        = (cyc < 2) || (cyc > 400 && $urandom_range(0, 599) == 0);
            blink_sync = (cyc == 360) || ($urandom_range(0, 179) == 0);
            if (cyc % 97 == 0) begin
                blink_mask = 8'($urandom);
                blank_mask = 8'($urandom & $urandom & $urandom);
            end
            if (cyc >= 1200 && cyc < 1400) begin
                blink_mask[0] = 1'b1;
                blank_mask[0] = 1'b1;
            end
            if (cyc % 13 == 0) digit_code = (cyc < 100) ? 32'h1234_5678 : $urandom;
            dp_mask = 8'($urandom);

            @(posedge msecclk);
            if (rst) begin
                exp_a  = 16'hFFFF;
                exp_b  = 16'h0000;
                scan_t = 0;
                since  = 0;
            end else begin
                exp_a = model_pins(8, 2, HALF_A, 1'b1, scan_t, since, digit_code,
                                   dp_mask, blink_mask, blank_mask);
                exp_b = model_pins(4, 1, HALF_B, 1'b0, scan_t, since, {16'h0, digit_code[15:0]},
                                   {4'h0, dp_mask[3:0]}, {4'h0, blink_mask[3:0]},
                                   {4'h0, blank_mask[3:0]});
                scan_t++;
                since = blink_sync ? 0 : since + 1;
            end
            eon_a = ((since / HALF_A) % 2) == 0;
            eon_b = ((since / HALF_B) % 2) == 0;

            #1;
            check_eq("an_8dig",    32'(an_a),  32'(exp_a[15:8]));
            check_eq("seg_8dig",   32'(seg_a), 32'(exp_a[7:0]));
            check_eq("blink_8dig", 32'(on_a),  32'(eon_a));
            check_eq("an_4dig",    32'(an_b),  32'(exp_b[11:8]));
            check_eq("seg_4dig",   32'(seg_b), 32'(exp_b[7:0]));
            check_eq("blink_4dig", 32'(on_b),  32'(eon_b));
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
